// File: rtl/rtc_bus_sequencer_if.sv
// Request/response ports of the two RTC requesters plus the multiplexed RTC pin bundle.
// The slave side is the sequencer; the master side is the requesters and the RTC chip.
interface rtc_bus_sequencer_if;
  logic       wr_req;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       wr_ack;
  logic       rd_req;
  logic [7:0] rd_addr;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       busy;
  logic [7:0] dato_out;
  logic       dato_oe;
  logic [7:0] dato_in;
  logic       AD;
  logic       CS;
  logic       WR;
  logic       RD;

  modport master (
    output wr_req, wr_addr, wr_data, rd_req, rd_addr, dato_in,
    input  wr_ack, rd_data, rd_valid, busy, dato_out, dato_oe, AD, CS, WR, RD
  );

  modport slave (
    input  wr_req, wr_addr, wr_data, rd_req, rd_addr, dato_in,
    output wr_ack, rd_data, rd_valid, busy, dato_out, dato_oe, AD, CS, WR, RD
  );
endinterface

// File: rtl/rtc_bus_sequencer.sv
// Round-robin arbiter plus two-phase (address, data) RTC bus cycle engine.
// All bus pins are registered; each state's outputs are set on the edge that enters it.
module rtc_bus_sequencer #(
  parameter int unsigned T_SETUP  = 2,
  parameter int unsigned T_STROBE = 5,
  parameter int unsigned T_HOLD   = 2,
  parameter int unsigned T_GAP    = 3
) (
  input logic                clk,
  input logic                reset,
  rtc_bus_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle, StASetup, StAStrobe, StAHold, StDSetup, StDStrobe, StDHold, StGap
  } state_e;

  localparam logic [7:0] CntSetup  = 8'(T_SETUP - 1);
  localparam logic [7:0] CntStrobe = 8'(T_STROBE - 1);
  localparam logic [7:0] CntHold   = 8'(T_HOLD - 1);
  localparam logic [7:0] CntGap    = 8'(T_GAP - 1);

  state_e     r_state;
  logic [7:0] r_cnt;
  logic [7:0] r_addr;
  logic [7:0] r_wdata;
  logic [7:0] r_cap;
  logic       r_is_rd;
  logic       r_last_rd;
  logic       r_wr_ack;
  logic       r_rd_valid;
  logic [7:0] r_rd_data;
  logic       r_busy;
  logic [7:0] r_dout;
  logic       r_oe;
  logic       r_ad;
  logic       r_cs;
  logic       r_wr;
  logic       r_rd;

  logic w_done;
  logic w_grant_rd;

  assign w_done = (r_cnt == 8'd0);
  // On contention, pick whichever side was not served last.
  assign w_grant_rd = bus.rd_req && (!bus.wr_req || !r_last_rd);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= StIdle;
      r_cnt      <= 8'd0;
      r_addr     <= 8'd0;
      r_wdata    <= 8'd0;
      r_cap      <= 8'd0;
      r_is_rd    <= 1'b0;
      r_last_rd  <= 1'b1;
      r_wr_ack   <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= 8'd0;
      r_busy     <= 1'b0;
      r_dout     <= 8'd0;
      r_oe       <= 1'b0;
      r_ad       <= 1'b1;
      r_cs       <= 1'b1;
      r_wr       <= 1'b1;
      r_rd       <= 1'b1;
    end else begin
      r_wr_ack   <= 1'b0;
      r_rd_valid <= 1'b0;
      if (r_state != StIdle && !w_done) begin
        r_cnt <= r_cnt - 8'd1;
      end
      unique case (r_state)
        StIdle: begin
          if (bus.wr_req || bus.rd_req) begin
            r_is_rd   <= w_grant_rd;
            r_last_rd <= w_grant_rd;
            r_addr    <= w_grant_rd ? bus.rd_addr : bus.wr_addr;
            r_wdata   <= bus.wr_data;
            r_state   <= StASetup;
            r_cnt     <= CntSetup;
            r_busy    <= 1'b1;
            r_cs      <= 1'b0;
            r_ad      <= 1'b0;
            r_oe      <= 1'b1;
            r_dout    <= w_grant_rd ? bus.rd_addr : bus.wr_addr;
          end
        end
        StASetup: if (w_done) begin
          r_state <= StAStrobe;
          r_cnt   <= CntStrobe;
          r_wr    <= 1'b0;
        end
        StAStrobe: if (w_done) begin
          r_state <= StAHold;
          r_cnt   <= CntHold;
          r_wr    <= 1'b1;
        end
        StAHold: if (w_done) begin
          r_state <= StDSetup;
          r_cnt   <= CntSetup;
          r_ad    <= 1'b1;
          r_oe    <= !r_is_rd;
          r_dout  <= r_is_rd ? 8'd0 : r_wdata;
        end
        StDSetup: if (w_done) begin
          r_state <= StDStrobe;
          r_cnt   <= CntStrobe;
          r_rd    <= !r_is_rd;
          r_wr    <= r_is_rd;
        end
        StDStrobe: if (w_done) begin
          r_state <= StDHold;
          r_cnt   <= CntHold;
          r_wr    <= 1'b1;
          r_rd    <= 1'b1;
          if (r_is_rd) begin
            r_cap <= bus.dato_in;
          end
        end
        StDHold: if (w_done) begin
          r_state <= StGap;
          r_cnt   <= CntGap;
          r_cs    <= 1'b1;
          r_oe    <= 1'b0;
          r_dout  <= 8'd0;
          if (r_is_rd) begin
            r_rd_valid <= 1'b1;
            r_rd_data  <= r_cap;
          end else begin
            r_wr_ack <= 1'b1;
          end
        end
        StGap: if (w_done) begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.wr_ack   = r_wr_ack;
  assign bus.rd_valid = r_rd_valid;
  assign bus.rd_data  = r_rd_data;
  assign bus.busy     = r_busy;
  assign bus.dato_out = r_dout;
  assign bus.dato_oe  = r_oe;
  assign bus.AD       = r_ad;
  assign bus.CS       = r_cs;
  assign bus.WR       = r_wr;
  assign bus.RD       = r_rd;

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Scoreboard bench for rtc_bus_sequencer: directed requests push expected transactions,
// a negedge bus monitor reconstructs each bus cycle and checks it when the ack/valid appears.
module tb_rtc_bus_sequencer;

  typedef struct {
    logic        is_rd;
    logic [7:0]  addr;
    logic [7:0]  data;
    int unsigned ack_cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  int unsigned cyc = 0;
  logic [7:0]  rtc_val = 8'h00;
  int unsigned checks = 0;
  int unsigned errors = 0;
  exp_t        q[$];

  rtc_bus_sequencer_if bus ();

  rtc_bus_sequencer #(
    .T_SETUP (2),
    .T_STROBE(5),
    .T_HOLD  (2),
    .T_GAP   (3)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RTC chip model: drives its register value only while RD is low.
  assign bus.dato_in = (bus.RD == 1'b0) ? rtc_val : 8'h00;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t mk(input logic is_rd, input logic [7:0] addr, input logic [7:0] data,
                              input int unsigned ack_cyc);
    exp_t e;
    e.is_rd   = is_rd;
    e.addr    = addr;
    e.data    = data;
    e.ack_cyc = ack_cyc;
    return e;
  endfunction

  // Bus monitor state
  logic        in_txn = 1'b0;
  int unsigned t_start, off, cs_n, ack_cnt = 0, both_low = 0;
  logic [7:0]  a_addr, d_data;
  logic        a_bad, d_seen, d_oe, d_bad, pend_pulse = 1'b0;
  int unsigned a_wr_first, a_wr_n, a_rd_n, d_wr_first, d_wr_n, d_rd_first, d_rd_n;

  task automatic score();
    exp_t e;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_ack actual=ack required=no_ack (cycle %0d)", cyc);
    end else begin
      e = q.pop_front();
      chk("ack_is_read", 32'(bus.rd_valid), 32'(e.is_rd));
      chk("ack_cycle", cyc, e.ack_cyc);
      chk("addr", 32'(a_addr), 32'(e.addr));
      chk("addr_stable", 32'(a_bad), 0);
      chk("cs_low_cycles", cs_n, 18);
      chk("a_strobe_start", a_wr_first, 2);
      chk("a_strobe_len", a_wr_n, 5);
      chk("a_rd_low", a_rd_n, 0);
      chk("d_stable", 32'(d_bad), 0);
      chk("busy_at_ack", 32'(bus.busy), 1);
      chk("cs_at_ack", 32'(bus.CS), 1);
      if (e.is_rd) begin
        chk("rd_data", 32'(bus.rd_data), 32'(e.data));
        chk("rd_d_oe", 32'(d_oe), 0);
        chk("rd_d_out", 32'(d_data), 0);
        chk("rd_strobe_start", d_rd_first, 11);
        chk("rd_strobe_len", d_rd_n, 5);
        chk("rd_d_wr_low", d_wr_n, 0);
      end else begin
        chk("wr_d_out", 32'(d_data), 32'(e.data));
        chk("wr_d_oe", 32'(d_oe), 1);
        chk("wr_strobe_start", d_wr_first, 11);
        chk("wr_strobe_len", d_wr_n, 5);
        chk("wr_d_rd_low", d_rd_n, 0);
      end
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (reset) begin
      in_txn     = 1'b0;
      pend_pulse = 1'b0;
    end else begin
      if (!bus.WR && !bus.RD) both_low++;
      if (pend_pulse) begin
        chk("ack_pulse_width", 32'(bus.wr_ack | bus.rd_valid), 0);
        pend_pulse = 1'b0;
      end
      if (!bus.CS) begin
        if (!in_txn) begin
          in_txn = 1'b1; t_start = cyc; cs_n = 0; a_addr = bus.dato_out; a_bad = 1'b0;
          a_wr_first = 0; a_wr_n = 0; a_rd_n = 0; d_seen = 1'b0; d_data = 8'h00;
          d_oe = 1'b0; d_bad = 1'b0; d_wr_first = 0; d_wr_n = 0; d_rd_first = 0; d_rd_n = 0;
        end
        off = cyc - t_start;
        cs_n++;
        if (!bus.AD) begin
          if (bus.dato_out !== a_addr || bus.dato_oe !== 1'b1) a_bad = 1'b1;
          if (!bus.WR) begin
            if (a_wr_n == 0) a_wr_first = off;
            a_wr_n++;
          end
          if (!bus.RD) a_rd_n++;
        end else begin
          if (!d_seen) begin
            d_seen = 1'b1; d_data = bus.dato_out; d_oe = bus.dato_oe;
          end
          if (bus.dato_out !== d_data || bus.dato_oe !== d_oe) d_bad = 1'b1;
          if (!bus.WR) begin
            if (d_wr_n == 0) d_wr_first = off;
            d_wr_n++;
          end
          if (!bus.RD) begin
            if (d_rd_n == 0) d_rd_first = off;
            d_rd_n++;
          end
        end
      end else begin
        in_txn = 1'b0;
      end
      if (bus.wr_ack || bus.rd_valid) begin
        ack_cnt++;
        pend_pulse = 1'b1;
        score();
      end
    end
  end

  task automatic check_idle(input string tag);
    chk({tag, "_AD"}, 32'(bus.AD), 1);
    chk({tag, "_CS"}, 32'(bus.CS), 1);
    chk({tag, "_WR"}, 32'(bus.WR), 1);
    chk({tag, "_RD"}, 32'(bus.RD), 1);
    chk({tag, "_oe"}, 32'(bus.dato_oe), 0);
    chk({tag, "_dout"}, 32'(bus.dato_out), 0);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_rd_data"}, 32'(bus.rd_data), 0);
    chk({tag, "_acks"}, 32'(bus.wr_ack | bus.rd_valid), 0);
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (bus.busy && n < 100);
    if (bus.busy) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout actual=busy required=idle (cycle %0d)", cyc);
    end
  endtask

  task automatic wait_ack(input bit is_rd);
    bit seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = is_rd ? bus.rd_valid : bus.wr_ack;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout actual=none required=%s (cycle %0d)",
               is_rd ? "rd_valid" : "wr_ack", cyc);
    end
    @(posedge clk);
    #1;
    if (is_rd) bus.rd_req = 1'b0;
    else bus.wr_req = 1'b0;
  endtask

  task automatic issue(input bit is_rd, input logic [7:0] addr, input logic [7:0] data,
                       output int unsigned g);
    wait_idle();
    g = cyc;
    q.push_back(mk(is_rd, addr, data, g + 19));
    if (is_rd) begin
      rtc_val     = data;
      bus.rd_addr = addr;
      bus.rd_req  = 1'b1;
    end else begin
      bus.wr_addr = addr;
      bus.wr_data = data;
      bus.wr_req  = 1'b1;
    end
    wait_ack(is_rd);
  endtask

  task automatic both_pair(input logic [7:0] wa, input logic [7:0] wd, input logic [7:0] ra,
                           input logic [7:0] rv);
    int unsigned g;
    wait_idle();
    g = cyc;
    rtc_val = rv;
    q.push_back(mk(1'b0, wa, wd, g + 19));
    q.push_back(mk(1'b1, ra, rv, g + 41));
    bus.wr_addr = wa;
    bus.wr_data = wd;
    bus.rd_addr = ra;
    bus.wr_req  = 1'b1;
    bus.rd_req  = 1'b1;
    fork
      wait_ack(1'b0);
      wait_ack(1'b1);
    join
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned g;
    int unsigned acks_before;
    bus.wr_req  = 1'b0;
    bus.rd_req  = 1'b0;
    bus.wr_addr = 8'h00;
    bus.wr_data = 8'h00;
    bus.rd_addr = 8'h00;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_idle("reset");
    end
    @(posedge clk);
    #1 reset = 1'b0;

    issue(1'b0, 8'h21, 8'h35, g);
    issue(1'b1, 8'h22, 8'h59, g);
    repeat (g + 40 - cyc) @(posedge clk);
    @(negedge clk);
    chk("rd_data_hold", 32'(bus.rd_data), 32'h59);

    // Address change mid-transaction must not reach the bus until the next grant.
    wait_idle();
    g = cyc;
    q.push_back(mk(1'b0, 8'h21, 8'h44, g + 19));
    bus.wr_addr = 8'h21;
    bus.wr_data = 8'h44;
    bus.wr_req  = 1'b1;
    repeat (5) @(posedge clk);
    #1 bus.wr_addr = 8'h7F;
    wait_ack(1'b0);
    issue(1'b0, 8'h7F, 8'h66, g);

    // Reset during the data strobe of a write.
    wait_idle();
    g = cyc;
    bus.wr_addr = 8'h55;
    bus.wr_data = 8'hAA;
    bus.wr_req  = 1'b1;
    repeat (13) @(posedge clk);
    #1;
    reset       = 1'b1;
    bus.wr_req  = 1'b0;
    acks_before = ack_cnt;
    @(posedge clk);
    @(negedge clk);
    check_idle("midreset");
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (30) @(posedge clk);
    chk("no_ack_after_reset", ack_cnt, acks_before);

    both_pair(8'h10, 8'hA5, 8'h11, 8'h3C);
    both_pair(8'h30, 8'h5A, 8'h31, 8'hC3);

    repeat (5) @(posedge clk);
    chk("queue_empty", q.size(), 0);
    chk("both_strobes_low", both_low, 0);
    chk("total_acks", ack_cnt, 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
